// File: rtl/dmem_port_pkg.sv
// Shared core constants: opcodes, ALU ops, load/store sizes, dmem FSM.
// Also the registered request bundle and access legality helpers.
package dmem_port_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
      ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND
   } alu_op_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic [2:0] funct3;
      logic [1:0] off;
   } dmem_req_t;

   function automatic logic f3_legal(
      input logic       is_load,
      input logic [2:0] f3
   );
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (is_load)
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

   // Size lives in funct3[1:0]: 0 byte, 1 half, 2 word.
   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      return ((f3[1:0] == 2'd1) && off[0]) ||
             ((f3[1:0] == 2'd2) && (off != 2'd0));
   endfunction

endpackage

// File: rtl/dmem_port_load_extend.sv
// Picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it according to the load funct3.
module load_extend
   import dmem_port_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH-1:0] word,
   input  logic [1:0]        offset,
   input  logic [2:0]        funct3,
   output logic [DWIDTH-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{offset, 3'b000} +: 8];
   assign half_sel = word[{offset[1], 4'b0000} +: 16];

   always_comb begin
      data = word;
      unique case (funct3)
         F3_B:    data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
         F3_H:    data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
         F3_BU:   data = {{(DWIDTH-8){1'b0}}, byte_sel};
         F3_HU:   data = {{(DWIDTH-16){1'b0}}, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dmem_port.sv
// Data memory port: one outstanding load/store against a
// single-cycle-read SRAM, with valid/ready request and response.
module dmem_port
   import dmem_port_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              memren_i,
   input  logic              memwren_i,
   input  logic [2:0]        funct3_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DWIDTH-1:0] rdata_o,
   output logic              err_o,
   output logic              sram_en_o,
   output logic [3:0]        sram_we_o,
   output logic [AWIDTH-3:0] sram_addr_o,
   output logic [DWIDTH-1:0] sram_wdata_o,
   input  logic [DWIDTH-1:0] sram_rdata_i
);

   state_t            state_q;
   state_t            state_d;
   dmem_req_t         req_q;
   logic [DWIDTH-1:0] rdata_q;
   logic              err_q;
   logic              accept;
   logic              bad;
   logic              go;
   logic [DWIDTH-1:0] ext_data;

   // Nothing is accepted while reset is held, so no SRAM
   // access can leak out during reset.
   assign req_ready_o = (state_q == IDLE) && !reset;
   assign accept = req_ready_o && req_valid_i &&
                   (memren_i || memwren_i);

   assign bad = (memren_i && memwren_i) ||
                !f3_legal(memren_i, funct3_i) ||
                misaligned(funct3_i, addr_i[1:0]);
   assign go = accept && !bad;

   assign rsp_valid_o = (state_q == RESP);
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;

   always_comb begin
      sram_en_o    = 1'b0;
      sram_we_o    = 4'b0000;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      if (go) begin
         sram_en_o   = 1'b1;
         sram_addr_o = addr_i[AWIDTH-1:2];
         if (memwren_i) begin
            unique case (1'b1)
               (funct3_i == F3_B): begin
                  sram_we_o    = 4'b0001 << addr_i[1:0];
                  sram_wdata_o = {(DWIDTH/8){wdata_i[7:0]}};
               end
               (funct3_i == F3_H): begin
                  sram_we_o    = 4'b0011 << addr_i[1:0];
                  sram_wdata_o = {(DWIDTH/16){wdata_i[15:0]}};
               end
               default: begin
                  sram_we_o    = 4'b1111;
                  sram_wdata_o = wdata_i;
               end
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept)
               state_d = (go && memren_i) ? RD_WAIT : RESP;
         end
         RD_WAIT: state_d = RESP;
         RESP: begin
            if (rsp_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   load_extend #(
      .DWIDTH(DWIDTH)
   ) u_ext (
      .word  (sram_rdata_i),
      .offset(req_q.off),
      .funct3(req_q.funct3),
      .data  (ext_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q.funct3 <= funct3_i;
            req_q.off    <= addr_i[1:0];
            rdata_q      <= '0;
            err_q        <= bad;
         end else if (state_q == RD_WAIT) begin
            rdata_q <= ext_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: loads, stores, errors,
// response backpressure and reset during an in-flight read.
module tb_dmem_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        memren;
   logic        memwren;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rdata;
   logic        err;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [29:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [31:0] rd_word;

   int vecs = 0;
   int errs = 0;

   dmem_port #(.DWIDTH(32), .AWIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .memren_i    (memren),
      .memwren_i   (memwren),
      .funct3_i    (funct3),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rdata_o     (rdata),
      .err_o       (err),
      .sram_en_o   (sram_en),
      .sram_we_o   (sram_we),
      .sram_addr_o (sram_addr),
      .sram_wdata_o(sram_wdata),
      .sram_rdata_i(sram_rdata)
   );

   always #5 clk = ~clk;

   // SRAM model: read data valid exactly one cycle after a read.
   always @(posedge clk) begin
      if (sram_en && sram_we == 4'b0000)
         sram_rdata <= rd_word;
      else
         sram_rdata <= 32'hDEAD_BEEF;
   end

   task automatic idle_inputs;
      req_valid = 1'b0;
      memren    = 1'b0;
      memwren   = 1'b0;
      funct3    = 3'd7;
      addr      = 32'hFFFF_FFFF;
      wdata     = 32'hFFFF_FFFF;
   endtask

   task automatic handshake;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      rsp_ready = 1'b0;
      rd_word = 32'h0;
      repeat (2) @(negedge clk);
      vecs++;
      if (rsp_valid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 ||
          sram_en !== 1'b0 || sram_we !== 4'h0 ||
          sram_addr !== 30'h0 || sram_wdata !== 32'h0) begin
         errs++;
         $display("FAIL reset_outs: rv=%b err=%b rd=%h en=%b we=%b a=%h wd=%h, want all 0",
                  rsp_valid, err, rdata, sram_en, sram_we, sram_addr, sram_wdata);
      end
      reset = 1'b0;
      #1;
      vecs++;
      if (req_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_loads;
      logic [2:0]  f3 [6];
      logic [31:0] ad [6];
      logic [31:0] wd [6];
      logic [31:0] ex [6];
      f3 = '{3'd0, 3'd5, 3'd2, 3'd4, 3'd1, 3'd0};
      ad = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1000, 32'h1002};
      wd = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234,
             32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234};
      ex = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h80FF_1234,
             32'h0000_0012, 32'h0000_1234, 32'hFFFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rd_word   = wd[i];
         req_valid = 1'b1;
         memren    = 1'b1;
         memwren   = 1'b0;
         funct3    = f3[i];
         addr      = ad[i];
         #1;
         vecs++;
         if (req_ready !== 1'b1 || sram_en !== 1'b1 ||
             sram_we !== 4'h0 || sram_addr !== ad[i][31:2]) begin
            errs++;
            $display("FAIL load_acc[%0d]: rdy=%b en=%b we=%b a=%h want 1 1 0 %h",
                     i, req_ready, sram_en, sram_we, sram_addr, ad[i][31:2]);
         end
         @(posedge clk);
         #1 idle_inputs();
         @(negedge clk);
         vecs++;
         if (rsp_valid !== 1'b0 || sram_en !== 1'b0) begin
            errs++;
            $display("FAIL load_wait[%0d]: rv=%b en=%b want 0 0",
                     i, rsp_valid, sram_en);
         end
         @(negedge clk);
         vecs++;
         if (rsp_valid !== 1'b1 || rdata !== ex[i] || err !== 1'b0) begin
            errs++;
            $display("FAIL load_rsp[%0d]: rv=%b rd=%h err=%b want 1 %h 0",
                     i, rsp_valid, rdata, err, ex[i]);
         end
         handshake();
      end
   endtask

   task automatic test_stores;
      logic [2:0]  f3 [3];
      logic [31:0] ad [3];
      logic [31:0] wd [3];
      logic [3:0]  we [3];
      logic [31:0] sw [3];
      f3 = '{3'd1, 3'd0, 3'd2};
      ad = '{32'h2002, 32'h2001, 32'h2004};
      wd = '{32'h0000_BEEF, 32'h1234_56A5, 32'hCAFE_F00D};
      we = '{4'b1100, 4'b0010, 4'b1111};
      sw = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'hCAFE_F00D};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         memren    = 1'b0;
         memwren   = 1'b1;
         funct3    = f3[i];
         addr      = ad[i];
         wdata     = wd[i];
         #1;
         vecs++;
         if (sram_en !== 1'b1 || sram_we !== we[i] ||
             sram_addr !== ad[i][31:2] || sram_wdata !== sw[i]) begin
            errs++;
            $display("FAIL store_acc[%0d]: en=%b we=%b a=%h wd=%h want 1 %b %h %h",
                     i, sram_en, sram_we, sram_addr, sram_wdata,
                     we[i], ad[i][31:2], sw[i]);
         end
         @(posedge clk);
         #1 idle_inputs();
         @(negedge clk);
         vecs++;
         if (rsp_valid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0 ||
             sram_en !== 1'b0 || sram_we !== 4'h0) begin
            errs++;
            $display("FAIL store_rsp[%0d]: rv=%b rd=%h err=%b en=%b we=%b want 1 0 0 0 0",
                     i, rsp_valid, rdata, err, sram_en, sram_we);
         end
         handshake();
      end
   endtask

   task automatic test_errors;
      logic        rn [4];
      logic        wn [4];
      logic [2:0]  f3 [4];
      logic [31:0] ad [4];
      rn = '{1'b1, 1'b1, 1'b1, 1'b0};
      wn = '{1'b0, 1'b1, 1'b0, 1'b1};
      f3 = '{3'd2, 3'd2, 3'd3, 3'd4};
      ad = '{32'h3001, 32'h3000, 32'h3000, 32'h3000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rd_word   = 32'h5555_5555;
         req_valid = 1'b1;
         memren    = rn[i];
         memwren   = wn[i];
         funct3    = f3[i];
         addr      = ad[i];
         wdata     = 32'h1111_2222;
         #1;
         vecs++;
         if (req_ready !== 1'b1 || sram_en !== 1'b0 || sram_we !== 4'h0) begin
            errs++;
            $display("FAIL err_acc[%0d]: rdy=%b en=%b we=%b want 1 0 0",
                     i, req_ready, sram_en, sram_we);
         end
         @(posedge clk);
         #1 idle_inputs();
         @(negedge clk);
         vecs++;
         if (rsp_valid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
            errs++;
            $display("FAIL err_rsp[%0d]: rv=%b err=%b rd=%h want 1 1 0",
                     i, rsp_valid, err, rdata);
         end
         handshake();
      end
      // Valid with neither strobe must not start anything.
      @(negedge clk);
      req_valid = 1'b1;
      funct3    = 3'd2;
      addr      = 32'h0;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      vecs++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errs++;
         $display("FAIL no_strobe: rdy=%b rv=%b want 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic ok;
      @(negedge clk);
      rd_word   = 32'h1234_5678;
      req_valid = 1'b1;
      memren    = 1'b1;
      funct3    = 3'd2;
      addr      = 32'h1000;
      @(posedge clk);
      // A competing store is held on the bus throughout the stall.
      #1;
      memren  = 1'b0;
      memwren = 1'b1;
      addr    = 32'h4000;
      wdata   = 32'hAAAA_BBBB;
      @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rdata !== 32'h1234_5678 ||
             req_ready !== 1'b0 || sram_en !== 1'b0)
            ok = 1'b0;
      end
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL stall_hold: rv=%b rd=%h rdy=%b want 1 12345678 0",
                  rsp_valid, rdata, req_ready);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      vecs++;
      if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_we !== 4'hF ||
          sram_addr !== 30'h1000) begin
         errs++;
         $display("FAIL next_accept: rdy=%b en=%b we=%b a=%h want 1 1 f 1000",
                  req_ready, sram_en, sram_we, sram_addr);
      end
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      handshake();
   endtask

   task automatic test_reset_mid;
      logic seen;
      @(negedge clk);
      rd_word   = 32'h8765_4321;
      req_valid = 1'b1;
      memren    = 1'b1;
      funct3    = 3'd2;
      addr      = 32'h1004;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      vecs++;
      if (rsp_valid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 ||
          sram_en !== 1'b0 || sram_we !== 4'h0) begin
         errs++;
         $display("FAIL mid_reset: rv=%b rd=%h err=%b en=%b want 0 0 0 0",
                  rsp_valid, rdata, err, sram_en);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      vecs++;
      if (req_ready !== 1'b1) begin
         errs++;
         $display("FAIL mid_release: rdy=%b want 1", req_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || rdata !== 32'h0)
            seen = 1'b1;
      end
      vecs++;
      if (seen) begin
         errs++;
         $display("FAIL mid_no_rsp: rv=%b rd=%h want 0 0", rsp_valid, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
